// File: rtl/spart_core_if.sv
// Driver-side control bundle for the SPART peripheral.
// databus stays a plain inout port on the core; this carries the rest.
interface spart_core_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_core.sv
// SPART peripheral: bus register decode, baud generator and
// 16x-oversampled 8N1 transmitter/receiver.
module spart_core #(
    parameter logic [15:0] RST_DIVISOR = 16'h028A,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    spart_core_if.slave bus,
    inout  wire  [7:0] databus,
    output logic       txd,
    input  logic       rxd
);
    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_e;
    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;

    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    tx_state_e   tx_state_q, tx_state_d;
    logic [3:0]  tx_tick_q, tx_tick_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tbr_q, tbr_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rx_state_e   rx_state_q, rx_state_d;
    logic [3:0]  rx_tick_q, rx_tick_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_buf_q, rx_buf_d;
    logic        rda_q, rda_d;
    logic        ovr_q, ovr_d;

    logic       wr, rd, div_wr, en16, rx_s, rx_done;
    logic       rd_rx, rd_st;
    logic [7:0] rdata;

    assign wr     = bus.iocs & ~bus.iorw;
    assign rd     = bus.iocs & bus.iorw;
    assign div_wr = wr & bus.ioaddr[1];
    assign rd_rx  = rd & (bus.ioaddr == 2'b00);
    assign rd_st  = rd & (bus.ioaddr == 2'b01);
    assign en16   = (cnt_q == 16'd0);
    assign rx_s   = sync_q[SYNC_STAGES-1];

    always_comb begin
        unique case (bus.ioaddr)
            2'b00:   rdata = rx_buf_q;
            2'b01:   rdata = {5'b0, ovr_q, rda_q, tbr_q};
            2'b10:   rdata = div_q[7:0];
            default: rdata = div_q[15:8];
        endcase
    end

    assign databus = rd ? rdata : 8'hzz;
    assign bus.rda = rda_q;
    assign bus.tbr = tbr_q;
    assign txd = (tx_state_q == TX_START) ? 1'b0 :
                 (tx_state_q == TX_DATA)  ? tx_sh_q[0] : 1'b1;

    // Baud generator; a divisor write restarts the count from the new value
    always_comb begin
        div_d = div_q;
        if (wr && bus.ioaddr == 2'b10) div_d[7:0]  = databus;
        if (wr && bus.ioaddr == 2'b11) div_d[15:8] = databus;
        if (div_wr)    cnt_d = div_d;
        else if (en16) cnt_d = div_q;
        else           cnt_d = cnt_q - 16'd1;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tbr_d      = tbr_q;
        if (wr && bus.ioaddr == 2'b01 && tbr_q) begin
            tx_sh_d = databus;
            tbr_d   = 1'b0;
        end
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!tbr_q && en16) begin
                    tx_state_d = TX_START;
                    tx_tick_d  = 4'd0;
                end
            end
            TX_START: begin
                if (en16) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        tx_state_d = TX_DATA;
                        tx_bit_d   = 3'd0;
                    end
                end
            end
            TX_DATA: begin
                if (en16) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_bit_d = tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (en16) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        tx_state_d = TX_IDLE;
                        tbr_d      = 1'b1;
                    end
                end
            end
        endcase
    end

    // Receiver samples mid-bit: 8 ticks into start, then every 16
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rxd};
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (en16 && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = 4'd0;
                end
            end
            RX_START: begin
                if (en16) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd7) begin
                        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                        rx_tick_d  = 4'd0;
                        rx_bit_d   = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (en16) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (en16) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_state_d = RX_IDLE;
                        rx_done    = rx_s;
                    end
                end
            end
        endcase
    end

    // A completing byte beats a same-edge read; ovr set beats its clear
    always_comb begin
        rx_buf_d = rx_buf_q;
        rda_d    = rda_q;
        ovr_d    = ovr_q;
        if (rd_rx) rda_d = 1'b0;
        if (rd_st) ovr_d = 1'b0;
        if (rx_done) begin
            rx_buf_d = rx_sh_q;
            rda_d    = 1'b1;
            if (rda_q && !rd_rx) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= RST_DIVISOR;
            cnt_q      <= RST_DIVISOR;
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'h00;
            tbr_q      <= 1'b1;
            sync_q     <= '1;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_buf_q   <= 8'h00;
            rda_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tbr_q      <= tbr_d;
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
            ovr_q      <= ovr_d;
        end
    end
endmodule

// File: tb/tb_spart_core.sv
// Directed bench for spart_core: registers, TX timing, RX handshake,
// overrun, glitch/framing rejection and txd->rxd loopback.
module tb_spart_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spart_core_if bus();
    wire  [7:0] databus;
    logic [7:0] drv = 8'h00;
    logic       drv_en = 1'b0;
    logic       txd;
    logic       rxd_tb = 1'b1;
    logic       loop = 1'b0;
    wire        rxd;

    assign databus = drv_en ? drv : 8'hzz;
    assign rxd     = loop ? txd : rxd_tb;

    spart_core dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .databus (databus),
        .txd     (txd),
        .rxd     (rxd)
    );

    int npass  = 0;
    int ntotal = 0;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a;
        drv = d; drv_en = 1'b1;
        @(negedge clk);
        bus.iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        bus.iocs = 1'b0; bus.iorw = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb,
                           input int bc, input logic pre);
        @(negedge clk);
        rxd_tb = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_tb = b[i];
            repeat (bc) @(negedge clk);
        end
        check("rx_rda_before_stop", bus.rda, pre);
        rxd_tb = stopb;
        repeat (bc) @(negedge clk);
        rxd_tb = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [9:0] frame;
        int n, pos, tgt;
        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_tbr", bus.tbr, 1'b1);
        check("rst_rda", bus.rda, 1'b0);
        rst = 1'b0;
        bus_rd(2'b01, d); check("rst_status", d, 8'h01);
        bus_rd(2'b00, d); check("rst_rxbuf", d, 8'h00);

        bus_wr(2'b01, 8'hA5);
        check("mid_tbr_low", bus.tbr, 1'b0);
        repeat (1000) @(negedge clk);
        check("mid_txd_start", txd, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_txd", txd, 1'b1);
        check("mid_rst_tbr", bus.tbr, 1'b1);
        check("mid_rst_rda", bus.rda, 1'b0);
        drv = 8'hC3; drv_en = 1'b1;
        #1 check("rst_bus_free", databus, 8'hC3);
        drv_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus_rd(2'b10, d); check("rst_div_lo", d, 8'h8A);
        bus_rd(2'b11, d); check("rst_div_hi", d, 8'h02);

        bus_wr(2'b10, 8'h45);
        bus_wr(2'b11, 8'h01);
        bus_rd(2'b10, d); check("div_lo", d, 8'h45);
        bus_rd(2'b11, d); check("div_hi", d, 8'h01);
        bus_wr(2'b01, 8'hA5);
        check("tx_tbr_low", bus.tbr, 1'b0);
        n = 0;
        while (txd !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("tx_fall", txd, 1'b0);
        frame = {1'b1, 8'hA5, 1'b0};
        repeat (2608) @(negedge clk);
        check("tx_bit0", txd, frame[0]);
        check("tx_tbr_mid", bus.tbr, 1'b0);
        repeat (5215 - 2608) @(negedge clk);
        check("tx_start_end", txd, 1'b0);
        @(negedge clk);
        check("tx_d0_begin", txd, 1'b1);
        pos = 5216;
        for (int k = 1; k < 10; k++) begin
            tgt = 2608 + k * 5216;
            repeat (tgt - pos) @(negedge clk);
            pos = tgt;
            check($sformatf("tx_bit%0d", k), txd, frame[k]);
        end
        repeat (52159 - pos) @(negedge clk);
        check("tx_tbr_stop", bus.tbr, 1'b0);
        @(negedge clk);
        check("tx_tbr_back", bus.tbr, 1'b1);
        check("tx_idle", txd, 1'b1);

        bus_wr(2'b10, 8'h50);
        bus_wr(2'b11, 8'h00);
        send_rx(8'h3C, 1'b1, 1296, 1'b0);
        check("rx_rda", bus.rda, 1'b1);
        bus_rd(2'b00, d); check("rx_data", d, 8'h3C);
        check("rx_rda_clr", bus.rda, 1'b0);

        bus_wr(2'b10, 8'h03);
        send_rx(8'h11, 1'b1, 64, 1'b0);
        send_rx(8'h22, 1'b1, 64, 1'b1);
        check("ovr_rda", bus.rda, 1'b1);
        bus_rd(2'b01, d); check("ovr_status", d, 8'h07);
        bus_rd(2'b00, d); check("ovr_data", d, 8'h22);
        bus_rd(2'b01, d); check("ovr_clr", d, 8'h01);

        @(negedge clk);
        rxd_tb = 1'b0;
        repeat (16) @(negedge clk);
        rxd_tb = 1'b1;
        repeat (768) @(negedge clk);
        check("glitch_rda", bus.rda, 1'b0);
        send_rx(8'h99, 1'b0, 64, 1'b0);
        repeat (256) @(negedge clk);
        check("frm_rda", bus.rda, 1'b0);
        bus_rd(2'b00, d); check("frm_buf", d, 8'h22);
        bus_rd(2'b01, d); check("frm_status", d, 8'h01);

        loop = 1'b1;
        bus_wr(2'b01, 8'h5A);
        bus_wr(2'b01, 8'hFF);
        check("lb_tbr_busy", bus.tbr, 1'b0);
        n = 0;
        while (bus.rda !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("lb_rda", bus.rda, 1'b1);
        bus_rd(2'b00, d); check("lb_data", d, 8'h5A);
        repeat (1500) @(negedge clk);
        check("lb_no_second", bus.rda, 1'b0);
        check("lb_tbr", bus.tbr, 1'b1);
        check("lb_txd_idle", txd, 1'b1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
